// File: rtl/uart_cmd_arbiter.sv
// uart_cmd_arbiter: shares one command-driven UART message sender among
// four requesters. Grants round-robin, issues the command with a start
// strobe, waits for acceptance and completion, then enforces an idle gap.
module uart_cmd_arbiter #(
  parameter int N_REQ          = 4,
  parameter int ACCEPT_TIMEOUT = 1000,
  parameter int GAP_CYCLES     = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_cmd,
  output logic [N_REQ-1:0]     req_ack,
  output logic [N_REQ-1:0]     req_done,
  output logic [7:0]           cmd_out,
  output logic                 cmd_str,
  input  logic                 cmd_ready,
  output logic                 busy,
  output logic [1:0]           grant_id,
  output logic                 err
);

  localparam int ID_W  = 2;
  localparam int ACC_W = (ACCEPT_TIMEOUT > 1) ? $clog2(ACCEPT_TIMEOUT) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(ACCEPT_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_ISSUE       = 3'd1;
  localparam logic [2:0] S_WAIT_ACCEPT = 3'd2;
  localparam logic [2:0] S_WAIT_DONE   = 3'd3;
  localparam logic [2:0] S_GAP         = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic              str_q, str_d;
  logic              err_q, err_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [GAP_W-1:0]  gap_q, gap_d;

  logic              found;
  logic [ID_W-1:0]   winner;

  // Round-robin pick: first asserted request at or above the pointer, with wrap.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[(int'(ptr_q) + k) % N_REQ]) begin
        found  = 1'b1;
        winner = ID_W'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  // Next-state and output logic for the grant/issue/accept/done/gap sequence.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    cmd_d   = cmd_q;
    ack_d   = '0;
    done_d  = '0;
    str_d   = str_q;
    err_d   = 1'b0;
    acc_d   = acc_q;
    gap_d   = gap_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_ready && found) begin
          cmd_d         = req_cmd[8*winner +: 8];
          gid_d         = winner;
          ack_d[winner] = 1'b1;
          ptr_d         = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        str_d   = 1'b1;
        acc_d   = '0;
        state_d = S_WAIT_ACCEPT;
      end
      S_WAIT_ACCEPT: begin
        // Acceptance wins over timeout when both happen in the same cycle.
        if (!cmd_ready) begin
          str_d   = 1'b0;
          state_d = S_WAIT_DONE;
        end else if (acc_q == ACC_LAST) begin
          str_d   = 1'b0;
          err_d   = 1'b1;
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          acc_d = acc_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (cmd_ready) begin
          done_d[gid_q] = 1'b1;
          gap_d         = '0;
          state_d       = S_GAP;
        end
      end
      S_GAP: begin
        if ((GAP_CYCLES == 0) || (gap_q == GAP_LAST)) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset drops any transaction in flight without pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      cmd_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      str_q   <= 1'b0;
      err_q   <= 1'b0;
      acc_q   <= '0;
      gap_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      cmd_q   <= cmd_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      str_q   <= str_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
      gap_q   <= gap_d;
    end
  end

  assign req_ack  = ack_q;
  assign req_done = done_q;
  assign cmd_out  = cmd_q;
  assign cmd_str  = str_q;
  assign grant_id = gid_q;
  assign err      = err_q;
  assign busy     = (state_q != S_IDLE);

endmodule
